// File: rtl/baud_pkg.sv
// Baud-rate table and round-half-up divisor helper for the UART timebase.
// Shared by baud_div_lut and baud_tick_gen (BAUD_EXT_DIV_EN adds the external-divisor select).
package baud_pkg;

  localparam int unsigned NUM_RATES = 12;
  localparam int unsigned SEL_W     = 4;

  // Highest table index, and the code reserved for the external divisor / reset value
  localparam logic [SEL_W-1:0] SEL_MAX = 4'd11;
  localparam logic [SEL_W-1:0] SEL_EXT = 4'hF;

  localparam int unsigned BAUD_TABLE [NUM_RATES] = '{
    300, 1200, 2400, 4800, 9600, 19200,
    38400, 57600, 115200, 230400, 460800, 921600
  };

  function automatic int unsigned div_of(input int unsigned clk_hz,
                                         input int unsigned baud);
    if (baud == 0) return 0;
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/baud_div_lut.sv
// Combinational baud select -> divisor lookup; table is fixed at elaboration.
// With BAUD_EXT_DIV_EN, select code 15 passes ext_div through.
module baud_div_lut
  import baud_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned CNT_W  = 19
) (
  input  logic [SEL_W-1:0] sel,
`ifdef BAUD_EXT_DIV_EN
  input  logic [CNT_W-1:0] ext_div,
`endif
  output logic [CNT_W-1:0] div_c,
  output logic             valid_c
);

  logic [CNT_W-1:0] div_tbl [NUM_RATES];

  for (genvar i = 0; i < NUM_RATES; i++) begin : g_rate
    localparam int unsigned DIV = div_of(CLK_HZ, BAUD_TABLE[i]);
    assign div_tbl[i] = CNT_W'(DIV);
  end

  always_comb begin
    div_c   = '0;
    valid_c = 1'b0;
    if (sel <= SEL_MAX) begin
      div_c   = div_tbl[sel];
      valid_c = 1'b1;
    end
`ifdef BAUD_EXT_DIV_EN
    else if (sel == SEL_EXT) begin
      div_c   = ext_div;
      valid_c = (ext_div != '0);
    end
`endif
  end

endmodule

// File: rtl/baud_tick_gen.sv
// UART bit-time counter producing registered bit, mid-bit and oversample strobes.
// Define BAUD_EXT_DIV_EN to add the ext_div input selectable with baud_sel 15.
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned CNT_W      = 19,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [SEL_W-1:0] baud_sel,
  input  logic             en,
  input  logic             restart,
`ifdef BAUD_EXT_DIV_EN
  input  logic [CNT_W-1:0] ext_div,
`endif
  output logic [CNT_W-1:0] k,
  output logic             valid,
  output logic             bit_tick,
  output logic             half_tick,
  output logic             os_tick
);

  logic [SEL_W-1:0] sel_q;
  logic [CNT_W-1:0] cnt, os_cnt;
  logic [CNT_W-1:0] lut_div;
  logic             lut_valid;

  logic             apply, reload;
  logic [CNT_W-1:0] os_div, half_div, k_m1, half_m1, os_m1;

  logic [CNT_W-1:0] k_d, cnt_d, os_cnt_d;
  logic             valid_d, bit_d, half_d, os_d;

  baud_div_lut #(
    .CLK_HZ (CLK_HZ),
    .CNT_W  (CNT_W)
  ) u_lut (
    .sel     (baud_sel),
`ifdef BAUD_EXT_DIV_EN
    .ext_div (ext_div),
`endif
    .div_c   (lut_div),
    .valid_c (lut_valid)
  );

  // A changed select re-applies the table; the external divisor also reloads on restart
  always_comb begin
    apply = (baud_sel != sel_q);
`ifdef BAUD_EXT_DIV_EN
    reload = apply || restart;
`else
    reload = apply;
`endif
  end

  // Compare points derived from the active divisor, each floored at one clock
  always_comb begin
    os_div = k / CNT_W'(OVERSAMPLE);
    if (os_div == '0) os_div = CNT_W'(1);
    half_div = k >> 1;
    if (half_div == '0) half_div = CNT_W'(1);
    k_m1    = k - CNT_W'(1);
    half_m1 = half_div - CNT_W'(1);
    os_m1   = os_div - CNT_W'(1);
  end

  always_comb begin
    k_d      = k;
    valid_d  = valid;
    cnt_d    = cnt;
    os_cnt_d = os_cnt;
    bit_d    = 1'b0;
    half_d   = 1'b0;
    os_d     = 1'b0;

    if (reload) begin
      k_d     = lut_div;
      valid_d = lut_valid;
    end

    if (apply || restart) begin
      cnt_d    = '0;
      os_cnt_d = '0;
    end else if (en && valid) begin
      bit_d    = (cnt == k_m1);
      half_d   = (cnt == half_m1);
      os_d     = (os_cnt == os_m1);
      cnt_d    = bit_d ? '0 : cnt + CNT_W'(1);
      os_cnt_d = (bit_d || os_d) ? '0 : os_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel_q     <= SEL_EXT;
      k         <= '0;
      valid     <= 1'b0;
      cnt       <= '0;
      os_cnt    <= '0;
      bit_tick  <= 1'b0;
      half_tick <= 1'b0;
      os_tick   <= 1'b0;
    end else begin
      sel_q     <= baud_sel;
      k         <= k_d;
      valid     <= valid_d;
      cnt       <= cnt_d;
      os_cnt    <= os_cnt_d;
      bit_tick  <= bit_d;
      half_tick <= half_d;
      os_tick   <= os_d;
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Randomized bench for baud_tick_gen against a cycle-phase reference model.
// Honours BAUD_EXT_DIV_EN when the design is built with it.
module tb_baud_tick_gen;

  localparam int unsigned CLK_HZ = 100_000_000;
  localparam int unsigned CNT_W  = 19;
  localparam int unsigned OVS    = 16;
  localparam int          NSEG   = 9;
`ifdef BAUD_EXT_DIV_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic [3:0]       baud_sel;
  logic             en;
  logic             restart;
  logic [CNT_W-1:0] ext_div;
  logic [CNT_W-1:0] k;
  logic             valid, bit_tick, half_tick, os_tick;

  int checks = 0;
  int errors = 0;

  int unsigned rates [12] = '{300, 1200, 2400, 4800, 9600, 19200,
                              38400, 57600, 115200, 230400, 460800, 921600};

  // Segment table: select (16 = random walk), length, en %, restart and reset per-mille
  int seg_sel [NSEG] = '{11,  8,     4,    13,   9,    10,   15,   11,   16};
  int seg_len [NSEG] = '{800, 2600,  11000, 1000, 1500, 3000, 1500, 3000, 8000};
  int seg_en  [NSEG] = '{100, 100,   100,  100,  100,  90,   95,   95,   95};
  int seg_rs  [NSEG] = '{0,   0,     0,    0,    0,    3,    5,    5,    2};
  int seg_rst [NSEG] = '{0,   0,     0,    0,    0,    0,    0,    3,    1};

  // Reference state: divisor, legality, clocks elapsed in the current bit
  int m_k, m_phase, m_sel_prev;
  bit m_valid, m_bt, m_ht, m_ot;

  baud_tick_gen #(
    .CLK_HZ     (CLK_HZ),
    .CNT_W      (CNT_W),
    .OVERSAMPLE (OVS)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .baud_sel  (baud_sel),
    .en        (en),
    .restart   (restart),
`ifdef BAUD_EXT_DIV_EN
    .ext_div   (ext_div),
`endif
    .k         (k),
    .valid     (valid),
    .bit_tick  (bit_tick),
    .half_tick (half_tick),
    .os_tick   (os_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_div(input int sel, input int ext);
    if (sel < 12) return int'((CLK_HZ + rates[sel] / 2) / rates[sel]);
    if (EXT && sel == 15) return ext;
    return 0;
  endfunction

  // Advance the reference across one rising edge with the given inputs
  task automatic model_step(input bit rst_ok, input int sel, input bit en_i,
                            input bit rs_i, input int ext);
    int hv;
    int od;
    m_bt = 1'b0;
    m_ht = 1'b0;
    m_ot = 1'b0;
    if (!rst_ok) begin
      m_k        = 0;
      m_valid    = 1'b0;
      m_phase    = 0;
      m_sel_prev = 15;
      return;
    end
    if (sel != m_sel_prev || (EXT && rs_i)) begin
      m_k     = ref_div(sel, ext);
      m_valid = (m_k != 0);
    end
    if (sel != m_sel_prev || rs_i) begin
      m_phase = 0;
    end else if (en_i && m_valid) begin
      hv = m_k / 2;
      if (hv == 0) hv = 1;
      od = m_k / OVS;
      if (od == 0) od = 1;
      m_bt    = (m_phase == m_k - 1);
      m_ht    = (m_phase == hv - 1);
      m_ot    = ((m_phase % od) == od - 1);
      m_phase = (m_phase + 1) % m_k;
    end
    m_sel_prev = sel;
  endtask

  function automatic logic [31:0] obs();
    return {9'b0, k, valid, bit_tick, half_tick, os_tick};
  endfunction

  function automatic logic [31:0] expv();
    return {9'b0, CNT_W'(m_k), m_valid, m_bt, m_ht, m_ot};
  endfunction

  initial begin
    int  cur_sel, cur_ext, cyc, last_bt, os_seen;
    bit  r_n, e, rs, abort;
    cur_sel = 0;
    cur_ext = 20;
    cyc     = 0;
    abort   = 1'b0;
    reset_n  = 1'b0;
    baud_sel = 4'd0;
    en       = 1'b0;
    restart  = 1'b0;
    ext_div  = CNT_W'(cur_ext);
    model_step(1'b0, 0, 1'b0, 1'b0, cur_ext);

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("reset", obs(), expv());
      model_step(1'b0, 0, 1'b0, 1'b0, cur_ext);
    end

    for (int s = 0; s < NSEG && !abort; s++) begin
      last_bt = -1;
      os_seen = 0;
      if (seg_sel[s] < 16) cur_sel = seg_sel[s];
      if (seg_sel[s] == 15) cur_ext = 20;
      for (int c = 0; c < seg_len[s] && !abort; c++) begin
        @(negedge clk);
        cyc++;
        chk("outs", obs(), expv());

        if (s == 0) begin
          if (half_tick && last_bt >= 0) chk("half_delay", cyc - last_bt, 54);
          if (bit_tick) begin
            if (last_bt >= 0) chk("bit_period", cyc - last_bt, 109);
            last_bt = cyc;
          end
        end
        if (s == 1) begin
          if (os_tick) os_seen++;
          if (bit_tick) begin
            if (last_bt >= 0) chk("os_per_bit", os_seen, 16);
            os_seen = 0;
            last_bt = cyc;
          end
        end
        if (errors > 100) abort = 1'b1;

        if (seg_sel[s] == 16 && $urandom_range(299) == 0) cur_sel = int'($urandom_range(15));
        if ($urandom_range(199) == 0) cur_ext = int'($urandom_range(40));
        r_n = !($urandom_range(999) < seg_rst[s]);
        e   = ($urandom_range(99) < seg_en[s]);
        rs  = ($urandom_range(999) < seg_rs[s]) || (s == 7 && c == 0);
        reset_n  = r_n;
        baud_sel = 4'(cur_sel);
        en       = e;
        restart  = rs;
        ext_div  = CNT_W'(cur_ext);
        model_step(r_n, cur_sel, e, rs, cur_ext);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
